mem_arbiter: RTL and testbench

//  Shares the single unified main-memory port between the I-cache and D-cache fill FSMs.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_outstanding_ctr.sv | 49 ++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter between the I- and D-cache fill FSMs.
package mem_arbiter_pkg;

  localparam int MEM_LAT_DEF = 4;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_outstanding_ctr.sv
// Saturating up/down count of memory reads issued but not yet returned.
module mem_arbiter_outstanding_ctr #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             dec_ok;

  // A return with nothing outstanding is spurious and must not underflow the count.
  always_comb begin
    count_d = count_q;
    dec_ok  = dec_i && (count_q != ZERO);
    if (inc_i && !dec_ok) begin
      if (count_q != MAX) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q;
      end
    end else if (dec_ok && !inc_i) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/mem_arbiter.sv
// Grants the unified memory port to one cache fill FSM at a time and routes read returns
// back to whichever cache issued them.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic              d_busy,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_dvld,
  output logic              d_dvld,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_dvld,
  output logic              err
);

  if (MEM_LAT + 1 > (1 << CNT_W) - 1) begin : g_cnt_w_check
    $error("mem_arbiter: CNT_W cannot hold MEM_LAT+1 outstanding reads");
  end

  arb_state_e       state_q;
  owner_e           last_q;
  logic             err_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             cnt_zero;
  logic             cnt_next_zero;
  logic             dvld_ok;

  mem_arbiter_outstanding_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .inc_i        (mem_en && !mem_wr),
    .dec_i        (mem_dvld),
    .count_o      (count),
    .count_next_o (count_next)
  );

  assign cnt_zero      = (count == {CNT_W{1'b0}});
  assign cnt_next_zero = (count_next == {CNT_W{1'b0}});
  assign dvld_ok       = mem_dvld && !cnt_zero;

  // Owner mux onto the memory port and return routing; in DRAIN returns go to the last owner.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    i_dvld    = 1'b0;
    d_dvld    = 1'b0;
    case (state_q)
      ARB_GNT_I: begin
        mem_en    = i_req;
        mem_wr    = i_req && i_wr;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_dvld    = dvld_ok;
      end
      ARB_GNT_D: begin
        mem_en    = d_req;
        mem_wr    = d_req && d_wr;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_dvld    = dvld_ok;
      end
      ARB_DRAIN: begin
        i_dvld = dvld_ok && (last_q == OWN_I);
        d_dvld = dvld_ok && (last_q == OWN_D);
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Arbitration FSM; ties in IDLE go to the side that did not own memory last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= OWN_I;
      err_q   <= 1'b0;
    end else begin
      if (mem_dvld && cnt_zero) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ARB_IDLE: begin
          if (d_req && (!i_req || last_q == OWN_I)) begin
            state_q <= ARB_GNT_D;
          end else if (i_req) begin
            state_q <= ARB_GNT_I;
          end
        end
        ARB_GNT_I: begin
          if (!i_busy && !i_req) begin
            last_q  <= OWN_I;
            state_q <= cnt_next_zero ? ARB_IDLE : ARB_DRAIN;
          end
        end
        ARB_GNT_D: begin
          if (!d_busy && !d_req) begin
            last_q  <= OWN_D;
            state_q <= cnt_next_zero ? ARB_IDLE : ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (cnt_next_zero) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign i_gnt = (state_q == ARB_GNT_I);
  assign d_gnt = (state_q == ARB_GNT_D);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle memory model and a scoreboard of read owners.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_wr = 1'b0, i_busy = 1'b0;
  logic [15:0] i_addr = 16'h0000, i_wdata = 16'h0000;
  logic        d_req = 1'b0, d_wr = 1'b0, d_busy = 1'b0;
  logic [15:0] d_addr = 16'h0000, d_wdata = 16'h0000;
  logic        i_gnt, d_gnt, i_dvld, d_dvld, mem_en, mem_wr, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_dvld = 1'b0;

  logic [3:0]  pipe = 4'b0000;
  logic        spur = 1'b0;
  logic        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          i_seen = 0;
  int          d_seen = 0;
  int          cyc = 0;
  int          last_d_cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_busy(i_busy), .i_addr(i_addr), .i_wdata(i_wdata),
    .d_req(d_req), .d_wr(d_wr), .d_busy(d_busy), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_dvld(i_dvld), .d_dvld(d_dvld),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dvld(mem_dvld), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted reads, advance the memory model, check return routing.
  task automatic tick();
    logic acc, own, del, was_rst, e;
    #2;
    acc = mem_en && !mem_wr && !rst;
    own = d_gnt;
    was_rst = rst;
    if (acc) exp_q.push_back(own);
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) exp_q.delete();
    pipe = {pipe[2:0], acc};
    del = pipe[3];
    mem_dvld = del | spur;
    spur = 1'b0;
    #1;
    if (del && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("route_i", {31'd0, i_dvld}, {31'd0, !e});
      chk("route_d", {31'd0, d_dvld}, {31'd0, e});
    end else begin
      chk("no_route_i", {31'd0, i_dvld}, 32'd0);
      chk("no_route_d", {31'd0, d_dvld}, 32'd0);
    end
    if (i_dvld) i_seen++;
    if (d_dvld) begin
      d_seen++;
      last_d_cyc = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    i_req = 1'b0; i_wr = 1'b0; i_busy = 1'b0;
    d_req = 1'b0; d_wr = 1'b0; d_busy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic want_i, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (want_i ? i_gnt : d_gnt) found = 1'b1;
      else tick();
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic found;
    int   gnt_cyc;

    // Reset state
    tick(); tick();
    chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // 1: I-cache miss alone, 8 reads
    i_seen = 0; d_seen = 0;
    i_req = 1'b1; i_busy = 1'b1; i_addr = 16'h1230;
    tick();
    chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      i_addr = 16'h1230 + 16'(2 * k);
      #1;
      chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
      chk("t1_mem_addr", {16'd0, mem_addr}, {16'd0, 16'h1230 + 16'(2 * k)});
      tick();
    end
    i_req = 1'b0;
    ticks(6);
    chk("t1_i_dvld_cnt", i_seen, 32'd8);
    chk("t1_d_dvld_cnt", d_seen, 32'd0);
    i_busy = 1'b0;
    tick();
    chk("t1_release", {31'd0, i_gnt}, 32'd0);
    ticks(3);

    // 2: tie after reset goes to D, then the tie at IDLE goes to I
    do_reset();
    i_req = 1'b1; i_busy = 1'b1; d_req = 1'b1; d_busy = 1'b1; d_addr = 16'h0040;
    tick();
    chk("t2_first_d", {31'd0, d_gnt}, 32'd1);
    chk("t2_first_not_i", {31'd0, i_gnt}, 32'd0);
    tick();
    d_req = 1'b0; d_busy = 1'b0;
    tick();
    d_req = 1'b1; d_busy = 1'b1;
    wait_gnt(1'b1, 20, "t2_i_after_d");
    chk("t2_d_waits", {31'd0, d_gnt}, 32'd0);
    i_req = 1'b0; i_busy = 1'b0;
    tick();
    wait_gnt(1'b0, 4, "t2_d_after_i");
    d_req = 1'b0; d_busy = 1'b0;
    ticks(8);

    // 3: D releases with 3 reads outstanding, pending I waits for the drain
    do_reset();
    d_seen = 0;
    d_req = 1'b1; d_busy = 1'b1;
    tick();
    chk("t3_d_gnt", {31'd0, d_gnt}, 32'd1);
    ticks(3);
    d_req = 1'b0; d_busy = 1'b0; i_req = 1'b1; i_busy = 1'b1;
    tick();
    chk("t3_drain_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("t3_drain_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("t3_drain_mem_en", {31'd0, mem_en}, 32'd0);
    found = 1'b0;
    gnt_cyc = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (i_gnt) begin
        found = 1'b1;
        gnt_cyc = cyc;
      end else begin
        tick();
      end
    end
    chk("t3_i_granted", {31'd0, found}, 32'd1);
    chk("t3_d_dvld_cnt", d_seen, 32'd3);
    chk("t3_gnt_after_idle", gnt_cyc - last_d_cyc, 32'd2);
    i_req = 1'b0; i_busy = 1'b0;
    ticks(8);

    // 4: posted write-through
    do_reset();
    d_req = 1'b1; d_wr = 1'b1; d_busy = 1'b1; d_addr = 16'h00A4; d_wdata = 16'hBEEF;
    tick();
    chk("t4_mem_en", {31'd0, mem_en}, 32'd1);
    chk("t4_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t4_mem_addr", {16'd0, mem_addr}, 32'h00A4);
    chk("t4_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    d_req = 1'b0; d_wr = 1'b0; d_busy = 1'b0; i_req = 1'b1; i_busy = 1'b1;
    #1;
    chk("t4_one_cycle", {31'd0, mem_en}, 32'd0);
    tick();
    chk("t4_released", {31'd0, d_gnt}, 32'd0);
    tick();
    chk("t4_count_zero", {31'd0, i_gnt}, 32'd1);
    i_req = 1'b0; i_busy = 1'b0;
    ticks(8);

    // 5: spurious mem_dvld in IDLE
    do_reset();
    spur = 1'b1;
    tick();
    chk("t5_no_i_dvld", {31'd0, i_dvld}, 32'd0);
    chk("t5_no_d_dvld", {31'd0, d_dvld}, 32'd0);
    tick();
    chk("t5_err", {31'd0, err}, 32'd1);
    ticks(3);
    chk("t5_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("t5_err_cleared", {31'd0, err}, 32'd0);

    // 6: reset mid-fill with two reads in flight
    d_req = 1'b1; d_busy = 1'b1;
    tick();
    tick(); tick();
    d_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("t6_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("t6_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    rst = 1'b0; d_busy = 1'b0;
    ticks(6);
    chk("t6_err_after", {31'd0, err}, 32'd1);
    chk("t6_still_idle", {31'd0, d_gnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
